// File: rtl/ddr3_app_responder.sv
// Responder-side model of the DDR3 MIG app_* interface. Commands and write data are queued,
// issued in order into a BRAM array, and reads return after a fixed latency.

module ddr3_app_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_push,
   input  logic [W-1:0] i_din,
   input  logic         i_pop,
   output logic [W-1:0] o_dout,
   output logic         o_empty,
   output logic         o_full
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // NOTE: storage arrays carry no reset; occupancy lives in the pointers alone, and an
   // un-reset array is what lets the tools map it onto RAM.
   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
   end

   assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
endmodule

module ddr3_app_responder #(
   parameter int ADDR_W       = 28,
   parameter int DATA_W       = 512,
   parameter int MEM_AW       = 10,
   parameter int CALIB_CYCLES = 64,
   parameter int RD_LAT       = 8,
   parameter int CMD_DEPTH    = 4,
   parameter int WDF_DEPTH    = 4,
   parameter int STALL_PERIOD = 0
) (
   input  logic                ui_clk,
   input  logic                ui_clk_sync_rst,
   input  logic [ADDR_W-1:0]   app_addr,
   input  logic [2:0]          app_cmd,
   input  logic                app_en,
   input  logic [DATA_W-1:0]   app_wdf_data,
   input  logic [DATA_W/8-1:0] app_wdf_mask,
   input  logic                app_wdf_wren,
   input  logic                app_wdf_end,
   output logic                app_rdy,
   output logic                app_wdf_rdy,
   output logic [DATA_W-1:0]   app_rd_data,
   output logic                app_rd_data_valid,
   output logic                app_rd_data_end,
   output logic                init_calib_complete
);
   localparam int         BE_W      = DATA_W / 8;
   localparam int         MEM_WORDS = 1 << MEM_AW;
   localparam int         CMD_W     = 3 + MEM_AW;
   localparam int         WDF_W     = BE_W + DATA_W;
   localparam int         CAL_W     = $clog2(CALIB_CYCLES + 1);
   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   typedef enum logic {ST_CALIB, ST_READY} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CAL_W-1:0]   r_calib_cnt;
   logic               w_ready;
   logic               w_stall;

   logic               w_cmd_push, w_cmd_pop, w_cmd_empty, w_cmd_full;
   logic [CMD_W-1:0]   w_cmd_dout;
   logic [2:0]         w_head_cmd;
   logic [MEM_AW-1:0]  w_head_idx;

   logic               w_wdf_push, w_wdf_pop, w_wdf_empty, w_wdf_full;
   logic [WDF_W-1:0]   w_wdf_dout;
   logic [DATA_W-1:0]  w_wdf_data;
   logic [BE_W-1:0]    w_wdf_mask;

   logic               w_issue_wr, w_issue_rd, w_issue_drop;

   logic [DATA_W-1:0]  r_mem [MEM_WORDS];
   logic [RD_LAT-1:0]  r_pipe_vld;
   logic [DATA_W-1:0]  r_pipe_data [RD_LAT];
   logic               r_rd_valid;
   logic [DATA_W-1:0]  r_rd_data;

   // Calibration: count CALIB_CYCLES edges, then stay READY until the next reset.
   always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
      if (ui_clk_sync_rst) begin
         r_state     <= ST_CALIB;
         r_calib_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_CALIB) r_calib_cnt <= r_calib_cnt + 1'b1;
      end
   end

   // NOTE: the default is assigned before any branch so every path drives w_state_nxt and no
   // latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      if (r_state == ST_CALIB && r_calib_cnt == CAL_W'(CALIB_CYCLES - 1))
         w_state_nxt = ST_READY;
   end

   assign w_ready = (r_state == ST_READY);

   generate
      if (STALL_PERIOD > 0) begin : g_stall
         localparam int SW = $clog2(STALL_PERIOD + 1);
         logic [SW-1:0] r_stall_cnt;

         always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
            if (ui_clk_sync_rst)                             r_stall_cnt <= '0;
            else if (r_stall_cnt == SW'(STALL_PERIOD - 1))   r_stall_cnt <= '0;
            else                                             r_stall_cnt <= r_stall_cnt + SW'(1);
         end

         assign w_stall = (r_stall_cnt == SW'(STALL_PERIOD - 1));
      end else begin : g_no_stall
         assign w_stall = 1'b0;
      end
   endgenerate

   assign app_rdy             = w_ready && !w_cmd_full && !w_stall;
   assign app_wdf_rdy         = w_ready && !w_wdf_full;
   assign init_calib_complete = w_ready;

   assign w_cmd_push = app_en && app_rdy;
   assign w_wdf_push = app_wdf_wren && app_wdf_rdy;

   ddr3_app_fifo #(.W(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .i_clk   (ui_clk),
      .i_rst   (ui_clk_sync_rst),
      .i_push  (w_cmd_push),
      .i_din   ({app_cmd, app_addr[MEM_AW+2:3]}),
      .i_pop   (w_cmd_pop),
      .o_dout  (w_cmd_dout),
      .o_empty (w_cmd_empty),
      .o_full  (w_cmd_full)
   );

   ddr3_app_fifo #(.W(WDF_W), .DEPTH(WDF_DEPTH)) u_wdf_fifo (
      .i_clk   (ui_clk),
      .i_rst   (ui_clk_sync_rst),
      .i_push  (w_wdf_push),
      .i_din   ({app_wdf_mask, app_wdf_data}),
      .i_pop   (w_wdf_pop),
      .o_dout  (w_wdf_dout),
      .o_empty (w_wdf_empty),
      .o_full  (w_wdf_full)
   );

   // Unused address bits alias onto the same word; end=0 beats are still full beats.
   logic w_unused;
   assign w_unused = ^{app_addr[ADDR_W-1:MEM_AW+3], app_addr[2:0], app_wdf_end};

   assign {w_head_cmd, w_head_idx} = w_cmd_dout;
   assign {w_wdf_mask, w_wdf_data} = w_wdf_dout;

   // A write at the head blocks everything behind it until its data beat arrives.
   assign w_issue_wr   = !w_cmd_empty && (w_head_cmd == CMD_WRITE) && !w_wdf_empty;
   assign w_issue_rd   = !w_cmd_empty && (w_head_cmd == CMD_READ);
   assign w_issue_drop = !w_cmd_empty && (w_head_cmd != CMD_WRITE) && (w_head_cmd != CMD_READ);
   assign w_cmd_pop    = w_issue_wr || w_issue_rd || w_issue_drop;
   assign w_wdf_pop    = w_issue_wr;

   // Array and read-data stages hold no reset; validity is tracked by r_pipe_vld.
   always_ff @(posedge ui_clk) begin
      if (w_issue_wr) begin
         for (int b = 0; b < BE_W; b++) begin
            if (!w_wdf_mask[b]) r_mem[w_head_idx][8*b +: 8] <= w_wdf_data[8*b +: 8];
         end
      end
      r_pipe_data[0] <= r_mem[w_head_idx];
      for (int i = 1; i < RD_LAT; i++) r_pipe_data[i] <= r_pipe_data[i-1];
   end

   always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
      if (ui_clk_sync_rst) begin
         r_pipe_vld <= '0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_pipe_vld[0] <= w_issue_rd;
         for (int i = 1; i < RD_LAT; i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
         r_rd_valid <= r_pipe_vld[RD_LAT-1];
         r_rd_data  <= r_pipe_vld[RD_LAT-1] ? r_pipe_data[RD_LAT-1] : '0;
      end
   end

   assign app_rd_data       = r_rd_data;
   assign app_rd_data_valid = r_rd_valid;
   assign app_rd_data_end   = r_rd_valid;
endmodule

// File: tb/tb_ddr3_app_responder.sv
// Directed bench for ddr3_app_responder: calibration, masked writes, write/data skew,
// stalled back-to-back reads and reset with reads in flight, checked through a read scoreboard.

module tb_ddr3_app_responder;
   localparam int LAT = 9;   // accept edge to valid edge: 1 issue cycle + RD_LAT

   localparam logic [511:0] D_A   = {16{32'hA5A5_0001}};
   localparam logic [511:0] D_FF  = '1;
   localparam logic [511:0] D_M   = {{504{1'b1}}, 8'h00};
   localparam logic [511:0] D_B4  = {8{64'hDEAD_BEEF_0000_0004}};
   localparam logic [511:0] D_B5  = {8{64'h0BAD_F00D_0000_0005}};
   localparam logic [2:0]   C_WR  = 3'b000;
   localparam logic [2:0]   C_RD  = 3'b001;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [27:0]  app_addr = '0;
   logic [2:0]   app_cmd = '0;
   logic         app_en = 1'b0;
   logic [511:0] app_wdf_data = '0;
   logic [63:0]  app_wdf_mask = '0;
   logic         app_wdf_wren = 1'b0;
   logic         app_wdf_end = 1'b0;
   logic         app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, init_calib_complete;
   logic [511:0] app_rd_data;

   typedef struct {
      logic [511:0] data;
      int           due;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   ddr3_app_responder #(.STALL_PERIOD(5)) dut (
      .ui_clk              (clk),
      .ui_clk_sync_rst     (rst),
      .app_addr            (app_addr),
      .app_cmd             (app_cmd),
      .app_en              (app_en),
      .app_wdf_data        (app_wdf_data),
      .app_wdf_mask        (app_wdf_mask),
      .app_wdf_wren        (app_wdf_wren),
      .app_wdf_end         (app_wdf_end),
      .app_rdy             (app_rdy),
      .app_wdf_rdy         (app_wdf_rdy),
      .app_rd_data         (app_rd_data),
      .app_rd_data_valid   (app_rd_data_valid),
      .app_rd_data_end     (app_rd_data_end),
      .init_calib_complete (init_calib_complete)
   );

   always #5 clk = ~clk;

   // Edges since reset release; matches the free-running stall counter phase.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %b, expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs == exp) else begin
         n_err++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Read-data monitor: any valid beat, or any expectation now due, pops the scoreboard.
   always @(negedge clk) begin
      if (app_rd_data_valid || (q.size() > 0 && q[0].due <= cyc)) begin
         if (q.size() == 0) begin
            check_bit("spurious_valid", app_rd_data_valid, 1'b0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check_bit("rd_valid", app_rd_data_valid, 1'b1);
            check_bit("rd_end", app_rd_data_end, 1'b1);
            check_int("rd_cycle", cyc, e.due);
            check("rd_data", app_rd_data, e.data);
         end
      end else if (app_rd_data_end) begin
         check_bit("stray_end", app_rd_data_end, 1'b0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [2:0] c, input logic [27:0] a, output int t);
      bit acc = 1'b0;
      int n = 0;
      app_cmd = c;
      app_addr = a;
      app_en = 1'b1;
      t = -1;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = app_rdy;
         step();
         n++;
      end
      app_en = 1'b0;
      t = cyc;
      if (!acc) check_bit("cmd_accept_timeout", 1'b0, 1'b1);
   endtask

   task automatic send_data(input logic [511:0] d, input logic [63:0] m);
      bit acc = 1'b0;
      int n = 0;
      app_wdf_data = d;
      app_wdf_mask = m;
      app_wdf_end = 1'b1;
      app_wdf_wren = 1'b1;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = app_wdf_rdy;
         step();
         n++;
      end
      app_wdf_wren = 1'b0;
      if (!acc) check_bit("data_accept_timeout", 1'b0, 1'b1);
   endtask

   task automatic write_beat(input logic [27:0] a, input logic [511:0] d, input logic [63:0] m);
      bit c_done = 1'b0, d_done = 1'b0, c_acc, d_acc;
      int n = 0;
      app_cmd = C_WR;
      app_addr = a;
      app_en = 1'b1;
      app_wdf_data = d;
      app_wdf_mask = m;
      app_wdf_end = 1'b1;
      app_wdf_wren = 1'b1;
      while (!(c_done && d_done) && n < 100) begin
         @(negedge clk);
         c_acc = app_en && app_rdy;
         d_acc = app_wdf_wren && app_wdf_rdy;
         step();
         n++;
         if (c_acc) begin c_done = 1'b1; app_en = 1'b0; end
         if (d_acc) begin d_done = 1'b1; app_wdf_wren = 1'b0; end
      end
      app_en = 1'b0;
      app_wdf_wren = 1'b0;
      if (!(c_done && d_done)) check_bit("write_timeout", 1'b0, 1'b1);
   endtask

   task automatic read_exp(input logic [27:0] a, input logic [511:0] d);
      int t;
      exp_t e;
      send_cmd(C_RD, a, t);
      e.data = d;
      e.due  = t + LAT;
      q.push_back(e);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 200) begin
         step();
         n++;
      end
      if (q.size() > 0) check_int("drain_timeout", q.size(), 0);
      repeat (12) step();
   endtask

   // Entered just after reset release: complete must rise on exactly the 64th edge.
   task automatic calib_check();
      int n = 0;
      @(negedge clk);
      check_bit("calib_early", init_calib_complete, 1'b0);
      while (cyc < 63 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_bit("calib_at_63", init_calib_complete, 1'b0);
      check_bit("rdy_in_calib", app_rdy, 1'b0);
      check_bit("wdf_rdy_in_calib", app_wdf_rdy, 1'b0);
      @(negedge clk);
      check_bit("calib_at_64", init_calib_complete, 1'b1);
      check_bit("wdf_rdy_ready", app_wdf_rdy, 1'b1);
      step();
   endtask

   initial begin
      logic [27:0] addr_tab [4];
      logic [511:0] data_tab [4];
      int t, i, n;
      bit acc;
      exp_t e;

      // Reset state
      #1 rst = 1'b1;
      #20;
      check_bit("rst_rdy", app_rdy, 1'b0);
      check_bit("rst_wdf_rdy", app_wdf_rdy, 1'b0);
      check_bit("rst_valid", app_rd_data_valid, 1'b0);
      check_bit("rst_end", app_rd_data_end, 1'b0);
      check_bit("rst_calib", init_calib_complete, 1'b0);
      check("rst_data", app_rd_data, '0);
      #12 rst = 1'b0;
      calib_check();

      // Basic write then read, latency checked by the monitor
      write_beat(28'h40, D_A, 64'h0);
      read_exp(28'h40, D_A);
      drain();

      // Byte mask: only byte 0 overwritten
      write_beat(28'h80, D_FF, 64'h0);
      write_beat(28'h80, '0, 64'hFFFF_FFFF_FFFF_FFFE);
      read_exp(28'h80, D_M);
      drain();

      // Command ahead of data, then data ahead of command
      send_cmd(C_WR, 28'h1C0, t);
      repeat (2) step();
      send_data(D_B4, 64'h0);
      send_data(D_B5, 64'h0);
      step();
      send_cmd(C_WR, 28'h200, t);
      repeat (4) step();
      read_exp(28'h1C0, D_B4);
      read_exp(28'h200, D_B5);
      drain();

      // Illegal command is accepted but has no effect
      send_cmd(3'b010, 28'h40, t);
      read_exp(28'h40, D_A);
      drain();

      // 16 back-to-back reads under stall, including aliased and low-bit addresses
      addr_tab = '{28'h2045, 28'h80, 28'h1C0, 28'h200};
      data_tab = '{D_A, D_M, D_B4, D_B5};
      i = 0;
      n = 0;
      app_cmd = C_RD;
      app_en = 1'b1;
      while (i < 16 && n < 200) begin
         app_addr = addr_tab[i % 4];
         @(negedge clk);
         check_bit("stall_rdy", app_rdy, (cyc % 5) != 4);
         acc = app_rdy;
         step();
         n++;
         if (acc) begin
            e.data = data_tab[i % 4];
            e.due  = cyc + LAT;
            q.push_back(e);
            i++;
         end
      end
      app_en = 1'b0;
      check_int("b2b_accepted", i, 16);
      drain();

      // Reset with three reads in flight: nothing may come back, memory survives
      read_exp(28'h40, D_A);
      read_exp(28'h80, D_M);
      read_exp(28'h200, D_B5);
      repeat (2) step();
      #2 rst = 1'b1;
      q.delete();
      repeat (3) step();
      check_bit("rst2_valid", app_rd_data_valid, 1'b0);
      check_bit("rst2_calib", init_calib_complete, 1'b0);
      #2 rst = 1'b0;
      calib_check();
      read_exp(28'h40, D_A);
      read_exp(28'h80, D_M);
      read_exp(28'h200, D_B5);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
